// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the load/store memory responder.
package mem_responder_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACCESS  = 2'd2,
        RELEASE = 2'd3
    } state_e;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_e;

    // Full-width compare, so addresses above DEPTH never alias onto real words.
    function automatic logic addr_in_range(input word_t addr, input int unsigned depth);
        return ({16'h0000, addr} < depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTHx16 register file: async reset to the preload image, synchronous write, combinational read.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned PRELOAD_ADDR = 3,
    parameter word_t       PRELOAD_VAL  = 16'h0004
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  word_t            wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output word_t            rd_data
);

    word_t mem_r [DEPTH];

    // Storage: reset image, then single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_r[i] <= (i == PRELOAD_ADDR) ? PRELOAD_VAL : 16'h0000;
            end
        end else if (we) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/mem_responder.sv
// Clocked load/store responder: request/ready handshake, programmable wait states, range check.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned PRELOAD_ADDR = 3,
    parameter logic [15:0] PRELOAD_VAL  = 16'h0004
)(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Addr,
    input  logic [15:0] WrData,
    input  logic        Store,
    input  logic        Load,
    output logic [15:0] RdData,
    output logic        Ready,
    output logic        Err
);

    // DEPTH must be at least 2 so the index has a non-zero width.
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

    state_e     state_r;
    logic [3:0] cnt_r;
    word_t      addr_r;
    word_t      wdata_r;
    op_e        op_r;
    word_t      rddata_r;
    logic       ready_r;
    logic       err_r;

    word_t      acc_addr_s;
    op_e        acc_op_s;
    logic       acc_hit_s;
    logic       go_access_s;
    logic       mem_we_s;
    word_t      mem_rdata_s;

    // Select the operation about to enter ACCESS: live inputs on a zero-wait accept, latches otherwise.
    always_comb begin
        acc_addr_s  = addr_r;
        acc_op_s    = op_r;
        go_access_s = 1'b0;
        if (state_r == IDLE) begin
            acc_addr_s  = Addr;
            acc_op_s    = Store ? OP_STORE : OP_LOAD;
            go_access_s = (Store || Load) && (WAIT_STATES == 32'd0);
        end else if (state_r == WAIT) begin
            go_access_s = (cnt_r == 4'd1);
        end else begin
            go_access_s = 1'b0;
        end
        acc_hit_s = addr_in_range(acc_addr_s, DEPTH);
        mem_we_s  = (state_r == ACCESS) && (op_r == OP_STORE) && addr_in_range(addr_r, DEPTH);
    end

    mem_array #(
        .DEPTH        (DEPTH),
        .IDX_W        (IDX_W),
        .PRELOAD_ADDR (PRELOAD_ADDR),
        .PRELOAD_VAL  (PRELOAD_VAL)
    ) u_mem (
        .clk     (Clock),
        .rst     (Reset),
        .we      (mem_we_s),
        .wr_idx  (addr_r[IDX_W-1:0]),
        .wr_data (wdata_r),
        .rd_idx  (acc_addr_s[IDX_W-1:0]),
        .rd_data (mem_rdata_s)
    );

    // Handshake FSM with request latches, wait counter and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            addr_r   <= 16'h0000;
            wdata_r  <= 16'h0000;
            op_r     <= OP_LOAD;
            rddata_r <= 16'h0000;
            ready_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            // Ready and Err are high only for the single cycle spent in ACCESS.
            ready_r <= go_access_s;
            err_r   <= go_access_s && !acc_hit_s;
            if (go_access_s && (acc_op_s == OP_LOAD)) begin
                rddata_r <= acc_hit_s ? mem_rdata_s : 16'h0000;
            end
            case (state_r)
                IDLE: begin
                    if (Store || Load) begin
                        addr_r  <= Addr;
                        wdata_r <= WrData;
                        op_r    <= acc_op_s;
                        cnt_r   <= WS_LOAD;
                        state_r <= (WAIT_STATES == 32'd0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_r <= RELEASE;
                end
                RELEASE: begin
                    if (!Store && !Load) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign RdData = rddata_r;
    assign Ready  = ready_r;
    assign Err    = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder: two instances (0 and 3 wait states) against an array model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic        st    [2];
    logic        ld    [2];
    logic [15:0] rd0, rd1;
    logic        rdy0, rdy1, err0, err1;

    logic [15:0] mmem [2][16];
    logic [15:0] mrd  [2];
    int          ws   [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_STATES(0)) dut0 (
        .Clock(clk), .Reset(rst), .Addr(addr[0]), .WrData(wdata[0]),
        .Store(st[0]), .Load(ld[0]), .RdData(rd0), .Ready(rdy0), .Err(err0)
    );

    mem_responder #(.WAIT_STATES(3)) dut3 (
        .Clock(clk), .Reset(rst), .Addr(addr[1]), .WrData(wdata[1]),
        .Store(st[1]), .Load(ld[1]), .RdData(rd1), .Ready(rdy1), .Err(err1)
    );

    function automatic logic rdy_of(input int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic err_of(input int d);
        return (d == 0) ? err0 : err1;
    endfunction

    function automatic logic [15:0] rd_of(input int d);
        return (d == 0) ? rd0 : rd1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mmem[d][i] = 16'h0000;
            mmem[d][3] = 16'h0004;
            mrd[d] = 16'h0000;
        end
    endtask

    // One complete handshake on instance d; hold = extra cycles the request stays high after Ready.
    task automatic xact(input int d, input logic st_i, input logic ld_i,
                        input logic [15:0] a, input logic [15:0] wd, input int hold);
        int          k;
        int          extra;
        logic        hit;
        logic [15:0] exp_rd;
        hit    = (a < 16'd16);
        exp_rd = st_i ? mrd[d] : (hit ? mmem[d][a[3:0]] : 16'h0000);
        @(negedge clk);
        st[d] = st_i; ld[d] = ld_i; addr[d] = a; wdata[d] = wd;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (!rdy_of(d)) begin
                addr[d]  = 16'($urandom);
                wdata[d] = 16'($urandom);
            end
        end while (!rdy_of(d) && k < 40);
        check_eq("latency", k, 32'(1 + ws[d]));
        check_eq("err", {31'd0, err_of(d)}, {31'd0, !hit});
        check_eq("rddata", {16'd0, rd_of(d)}, {16'd0, exp_rd});
        extra = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (rdy_of(d) || err_of(d)) extra++;
        end
        @(negedge clk);
        st[d] = 1'b0; ld[d] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rdy_of(d) || err_of(d)) extra++;
        end
        check_eq("extra_ready", extra, 32'd0);
        check_eq("rd_hold", {16'd0, rd_of(d)}, {16'd0, exp_rd});
        if (st_i && hit) mmem[d][a[3:0]] = wd;
        if (!st_i) mrd[d] = exp_rd;
    endtask

    task automatic sweep(input int d);
        for (int i = 0; i < 16; i++) xact(d, 1'b0, 1'b1, 16'(i), 16'h0000, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ws[0] = 0;
        ws[1] = 3;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; ld[d] = 1'b0; addr[d] = 16'h0000; wdata[d] = 16'h0000;
        end
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {30'd0, rdy0, rdy1}, 32'd0);
        check_eq("rst_err", {30'd0, err0, err1}, 32'd0);
        check_eq("rst_rddata", {rd0, rd1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases, zero wait states.
        xact(0, 1'b0, 1'b1, 16'd3, 16'h0000, 0);
        xact(0, 1'b0, 1'b1, 16'd5, 16'h0000, 1);
        xact(0, 1'b1, 1'b0, 16'd7, 16'hBEEF, 0);
        xact(0, 1'b0, 1'b1, 16'd7, 16'h0000, 0);
        xact(0, 1'b1, 1'b1, 16'd2, 16'h1234, 0);
        xact(0, 1'b0, 1'b1, 16'd2, 16'h0000, 0);
        xact(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 0);
        xact(0, 1'b1, 1'b0, 16'hFFFF, 16'h5555, 0);
        xact(0, 1'b1, 1'b0, 16'd9, 16'hA5A5, 10);
        sweep(0);

        // Directed cases, three wait states.
        xact(1, 1'b0, 1'b1, 16'd3, 16'h0000, 0);
        xact(1, 1'b1, 1'b0, 16'd7, 16'hBEEF, 2);
        xact(1, 1'b0, 1'b1, 16'd7, 16'h0000, 0);
        xact(1, 1'b1, 1'b0, 16'h0010, 16'h7777, 0);

        // Reset during the wait phase of a store aborts it.
        @(negedge clk);
        st[1] = 1'b1; addr[1] = 16'd3; wdata[1] = 16'hDEAD;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_ready", {30'd0, rdy0, rdy1}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("abort_hold", {30'd0, rdy1, err1}, 32'd0);
        end
        @(negedge clk);
        st[1] = 1'b0;
        rst = 1'b0;
        model_reset();
        check_eq("abort_rddata", {16'd0, rd1}, 32'd0);
        xact(1, 1'b0, 1'b1, 16'd3, 16'h0000, 0);

        // Randomised traffic on both instances.
        for (int n = 0; n < 60; n++) begin
            for (int d = 0; d < 2; d++) begin
                int          r;
                int          op;
                logic [15:0] a;
                r = $urandom_range(0, 9);
                if (r == 0)      a = 16'h0010;
                else if (r == 1) a = 16'($urandom);
                else             a = 16'($urandom_range(0, 15));
                op = $urandom_range(0, 2);
                xact(d, (op != 0), (op != 1), a, 16'($urandom), $urandom_range(0, 3));
            end
        end
        sweep(0);
        sweep(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
